// File: rtl/ikaopm_pkg.sv
// Shared types and constants for the OPM shell: register map, frame timing, DAC float word.
// Latency: n/a (declarations and pure combinational helpers only).
// Backpressure: n/a.
package ikaopm_pkg;

  localparam logic [7:0] REG_CLKA_HI  = 8'h10;
  localparam logic [7:0] REG_CLKA_LO  = 8'h11;
  localparam logic [7:0] REG_CLKB     = 8'h12;
  localparam logic [7:0] REG_TMR_CTRL = 8'h14;
  localparam logic [7:0] REG_CT       = 8'h1B;

  localparam int FRAME_LEN = 32;
  localparam int BUSY_LEN  = 32;

  // YM3012 word: 3-bit exponent, inverted mantissa sign, 9 mantissa bits
  typedef struct packed {
    logic [2:0] exp;
    logic       sgn;
    logic [8:0] man;
  } flt_word_t;

  // One sampled copy of the CPU bus
  typedef struct packed {
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic       a0;
    logic [7:0] d;
  } bus_smp_t;

  localparam bus_smp_t BUS_IDLE = '{cs_n: 1'b1, rd_n: 1'b1, wr_n: 1'b1, a0: 1'b0, d: 8'h00};

  // Smallest exponent whose shifted mantissa fits 10 signed bits; descending loop keeps the last (smallest) hit
  function automatic flt_word_t flt_enc(input logic signed [15:0] x);
    logic signed [15:0] s;
    flt_word_t w;
    w = '0;
    for (int e = 7; e >= 1; e--) begin
      s = x >>> (e - 1);
      if (s >= -16'sd512 && s <= 16'sd511) begin
        w.exp = 3'(e);
        w.sgn = ~s[9];
        w.man = s[8:0];
      end
    end
    return w;
  endfunction

  // Value the DAC reproduces from a word; exponent 0 only exists as the reset value
  function automatic logic signed [15:0] flt_dec(input flt_word_t w);
    logic signed [15:0] mx;
    mx = {{6{~w.sgn}}, ~w.sgn, w.man};
    if (w.exp == 3'd0) return '0;
    return mx <<< (w.exp - 3'd1);
  endfunction

endpackage

// File: rtl/ikaopm_if.sv
// CPU-side bus of the OPM: strobes, address select, write data, status read-back.
// Latency: n/a (wires only).
// Backpressure: none; the busy bit in o_D is advisory to the CPU.
interface ikaopm_if;
  logic       i_CS_n;
  logic       i_RD_n;
  logic       i_WR_n;
  logic       i_A0;
  logic [7:0] i_D;
  logic [7:0] o_D;
  logic       o_D_OE;

  modport master (output i_CS_n, i_RD_n, i_WR_n, i_A0, i_D, input o_D, o_D_OE);
  modport slave  (input i_CS_n, i_RD_n, i_WR_n, i_A0, i_D, output o_D, o_D_OE);
endinterface

// File: rtl/ikaopm_dac_ser.sv
// Float-encodes the frame's stereo sample and serialises it in YM3012 format (SO, SH1, SH2).
// Latency: samples latched at end of slot 0; right word bits on slots 3-15, left on 19-31.
// Backpressure: none; free-running on the phi1 frame.
module ikaopm_dac_ser
  import ikaopm_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               phi1_en,
  input  logic [4:0]         slot,
  input  logic signed [15:0] smp_l,
  input  logic signed [15:0] smp_r,
  output logic               so,
  output logic               sh1,
  output logic               sh2,
  output logic signed [15:0] emu_l,
  output logic signed [15:0] emu_r,
  output logic signed [15:0] emu_l_ex,
  output logic signed [15:0] emu_r_ex
);

  flt_word_t wrd_l, wrd_r;
  logic [12:0] half_bits;
  logic [3:0]  ofs;

  // Capture raw and encoded samples once per frame, during slot 0
  always_ff @(posedge clk) begin
    if (rst) begin
      emu_l <= '0;
      emu_r <= '0;
      wrd_l <= '0;
      wrd_r <= '0;
    end else if (phi1_en && slot == 5'd0) begin
      emu_l <= smp_l;
      emu_r <= smp_r;
      wrd_l <= flt_enc(smp_l);
      wrd_r <= flt_enc(smp_r);
    end
  end

  // Slot-decoded serial stream: 3 zero lead bits then 13 word bits LSB first per half
  always_comb begin
    half_bits = slot[4] ? wrd_l : wrd_r;
    ofs       = slot[3:0];
    so        = 1'b0;
    if (ofs >= 4'd3) so = half_bits[ofs - 4'd3];
    sh1       = ~slot[4] & slot[3];
    sh2       =  slot[4] & slot[3];
    emu_l_ex  = flt_dec(wrd_l);
    emu_r_ex  = flt_dec(wrd_r);
  end

endmodule

// File: rtl/ikaopm_shell.sv
// OPM shell: CPU bus decode, register file, busy, timers A/B with IRQ, CT pins, phi1, serial DAC.
// Latency: bus sync 2 EMUCLK + phiM alignment; o_REG_* and internal regs update on the same edge.
// Backpressure: none; writes during busy are accepted and restart the busy window.
module ikaopm_shell
  import ikaopm_pkg::*;
#(
  parameter bit FULLY_SYNCHRONOUS = 1'b1,
  parameter bit FAST_RESET        = 1'b1
) (
  input  logic               i_EMUCLK,
  input  logic               i_IC,
  input  logic               i_phiM_PCEN_n,
  input  logic               i_phi1_PCEN_n,
  input  logic               i_phi1_NCEN_n,
  output logic               o_phi1,
  ikaopm_if.slave            bus,
  output logic               o_CT1,
  output logic               o_CT2,
  output logic               o_IRQ_n,
  output logic               o_REG_WE,
  output logic [7:0]         o_REG_ADDR,
  output logic [7:0]         o_REG_DATA,
  input  logic signed [15:0] i_SMP_L,
  input  logic signed [15:0] i_SMP_R,
  output logic               o_SH1,
  output logic               o_SH2,
  output logic               o_SO,
  output logic signed [15:0] o_EMU_R,
  output logic signed [15:0] o_EMU_L,
  output logic signed [15:0] o_EMU_R_EX,
  output logic signed [15:0] o_EMU_L_EX
);

  logic rst, phim_en, phi1_en;
  assign phim_en = ~i_phiM_PCEN_n;
  assign phi1_en = ~i_phi1_PCEN_n;
  assign rst     = i_IC & (FAST_RESET | phi1_en);

  bus_smp_t bus_raw, bus_s1, bus_s2, bus_cur;
  assign bus_raw = '{cs_n: bus.i_CS_n, rd_n: bus.i_RD_n, wr_n: bus.i_WR_n, a0: bus.i_A0, d: bus.i_D};

  // Two-stage synchroniser for the CPU strobes and data
  always_ff @(posedge i_EMUCLK) begin
    if (rst) begin
      bus_s1 <= BUS_IDLE;
      bus_s2 <= BUS_IDLE;
    end else begin
      bus_s1 <= bus_raw;
      bus_s2 <= bus_s1;
    end
  end
  assign bus_cur = FULLY_SYNCHRONOUS ? bus_s2 : bus_raw;

  logic wr_act, wr_prev, wr_stb, addr_stb, data_stb;
  assign wr_act   = ~bus_cur.cs_n & ~bus_cur.wr_n;
  assign wr_stb   = phim_en & wr_act & ~wr_prev;
  assign addr_stb = wr_stb & ~bus_cur.a0;
  assign data_stb = wr_stb &  bus_cur.a0;

  // Write strobe level as seen on the previous phiM enable, for rising-edge detection
  always_ff @(posedge i_EMUCLK) begin
    if (rst)          wr_prev <= 1'b0;
    else if (phim_en) wr_prev <= wr_act;
  end

  logic [7:0] addr_lat, clkb;
  logic [9:0] clka;
  logic       run_a, run_b, irqen_a, irqen_b;
  logic [5:0] busy_cnt;
  logic       sel_ctrl, ld_a, ld_b, clr_a, clr_b;

  assign sel_ctrl = data_stb & (addr_lat == REG_TMR_CTRL);
  assign ld_a     = sel_ctrl & bus_cur.d[0] & ~run_a;
  assign ld_b     = sel_ctrl & bus_cur.d[1] & ~run_b;
  assign clr_a    = sel_ctrl & bus_cur.d[4];
  assign clr_b    = sel_ctrl & bus_cur.d[5];

  // Address latch, register file, pass-through to the FM core and busy window
  always_ff @(posedge i_EMUCLK) begin
    if (rst) begin
      addr_lat   <= '0;
      o_REG_WE   <= 1'b0;
      o_REG_ADDR <= '0;
      o_REG_DATA <= '0;
      clka       <= '0;
      clkb       <= '0;
      run_a      <= 1'b0;
      run_b      <= 1'b0;
      irqen_a    <= 1'b0;
      irqen_b    <= 1'b0;
      o_CT1      <= 1'b0;
      o_CT2      <= 1'b0;
      busy_cnt   <= '0;
    end else begin
      o_REG_WE <= data_stb;
      if (addr_stb) addr_lat <= bus_cur.d;
      if (data_stb) begin
        o_REG_ADDR <= addr_lat;
        o_REG_DATA <= bus_cur.d;
        case (addr_lat)
          REG_CLKA_HI:  clka[9:2] <= bus_cur.d;
          REG_CLKA_LO:  clka[1:0] <= bus_cur.d[1:0];
          REG_CLKB:     clkb      <= bus_cur.d;
          REG_TMR_CTRL: begin
            run_a   <= bus_cur.d[0];
            run_b   <= bus_cur.d[1];
            irqen_a <= bus_cur.d[2];
            irqen_b <= bus_cur.d[3];
          end
          REG_CT: begin
            o_CT1 <= bus_cur.d[6];
            o_CT2 <= bus_cur.d[7];
          end
          default: ;
        endcase
      end
      if (data_stb)                          busy_cnt <= 6'(BUSY_LEN);
      else if (phi1_en && busy_cnt != '0)    busy_cnt <= busy_cnt - 6'd1;
    end
  end

  logic [4:0] slot;
  logic [3:0] frm_div;
  logic [9:0] cnt_a;
  logic [7:0] cnt_b;
  logic       flag_a, flag_b, frame_end, tick_b;

  assign frame_end = (slot == 5'(FRAME_LEN - 1));
  assign tick_b    = frame_end & (frm_div == 4'hF);

  // Frame slot counter and timers; overflow set is ordered after clear so set wins
  always_ff @(posedge i_EMUCLK) begin
    if (rst) begin
      slot    <= '0;
      frm_div <= '0;
      cnt_a   <= '0;
      cnt_b   <= '0;
      flag_a  <= 1'b0;
      flag_b  <= 1'b0;
    end else begin
      if (clr_a) flag_a <= 1'b0;
      if (clr_b) flag_b <= 1'b0;
      if (ld_a) cnt_a <= clka;
      else if (phi1_en && frame_end && run_a) begin
        if (cnt_a == 10'h3FF) begin
          cnt_a <= clka;
          if (irqen_a) flag_a <= 1'b1;
        end else cnt_a <= cnt_a + 10'd1;
      end
      if (ld_b) cnt_b <= clkb;
      else if (phi1_en && tick_b && run_b) begin
        if (cnt_b == 8'hFF) begin
          cnt_b <= clkb;
          if (irqen_b) flag_b <= 1'b1;
        end else cnt_b <= cnt_b + 8'd1;
      end
      if (phi1_en) begin
        slot <= frame_end ? 5'd0 : slot + 5'd1;
        if (frame_end) frm_div <= frm_div + 4'd1;
      end
    end
  end

  // Regenerated phi1: rises on the positive enable, falls on the negative enable
  always_ff @(posedge i_EMUCLK) begin
    if (rst)                 o_phi1 <= 1'b0;
    else if (phi1_en)        o_phi1 <= 1'b1;
    else if (~i_phi1_NCEN_n) o_phi1 <= 1'b0;
  end

  assign bus.o_D    = {busy_cnt != '0, 5'b0, flag_b, flag_a};
  assign bus.o_D_OE = ~bus_cur.cs_n & ~bus_cur.rd_n;
  assign o_IRQ_n    = ~(flag_a | flag_b);

  ikaopm_dac_ser u_dac (
    .clk      (i_EMUCLK),
    .rst      (rst),
    .phi1_en  (phi1_en),
    .slot     (slot),
    .smp_l    (i_SMP_L),
    .smp_r    (i_SMP_R),
    .so       (o_SO),
    .sh1      (o_SH1),
    .sh2      (o_SH2),
    .emu_l    (o_EMU_L),
    .emu_r    (o_EMU_R),
    .emu_l_ex (o_EMU_L_EX),
    .emu_r_ex (o_EMU_R_EX)
  );

endmodule

// File: tb/tb_ikaopm_shell.sv
// Directed bench for the OPM shell: reset, bus writes, busy, timer A IRQ, DAC encoding/serial, mid-frame reset.
// Latency: phiM enable every 2 EMUCLK, phi1 enable every 4 EMUCLK (frame = 128 EMUCLK).
// Backpressure: n/a.
module tb_ikaopm_shell;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic ic = 1'b1;
  logic phim_pcen_n = 1'b1, phi1_pcen_n = 1'b1, phi1_ncen_n = 1'b1;
  logic signed [15:0] smp_l = '0, smp_r = '0;
  logic o_phi1, o_CT1, o_CT2, o_IRQ_n, o_REG_WE, o_SH1, o_SH2, o_SO;
  logic [7:0] o_REG_ADDR, o_REG_DATA;
  logic signed [15:0] o_EMU_R, o_EMU_L, o_EMU_R_EX, o_EMU_L_EX;

  ikaopm_if bus();

  ikaopm_shell dut (
    .i_EMUCLK(clk), .i_IC(ic),
    .i_phiM_PCEN_n(phim_pcen_n), .i_phi1_PCEN_n(phi1_pcen_n), .i_phi1_NCEN_n(phi1_ncen_n),
    .o_phi1(o_phi1), .bus(bus),
    .o_CT1(o_CT1), .o_CT2(o_CT2), .o_IRQ_n(o_IRQ_n),
    .o_REG_WE(o_REG_WE), .o_REG_ADDR(o_REG_ADDR), .o_REG_DATA(o_REG_DATA),
    .i_SMP_L(smp_l), .i_SMP_R(smp_r),
    .o_SH1(o_SH1), .o_SH2(o_SH2), .o_SO(o_SO),
    .o_EMU_R(o_EMU_R), .o_EMU_L(o_EMU_L), .o_EMU_R_EX(o_EMU_R_EX), .o_EMU_L_EX(o_EMU_L_EX)
  );

  int tests_run = 0, tests_failed = 0;

  // Enable generation first, then observation of the state before the next rising edge
  int unsigned div = 0;
  int we_cnt = 0, we_run = 0, we_maxrun = 0, busy_clks = 0;
  logic [7:0] we_addr = '0, we_data = '0;
  logic [15:0] so_sh = '0;
  logic [12:0] word_r = '0, word_l = '0;
  logic [2:0] lead_r = '0, lead_l = '0;
  logic sh1_q = 1'b0, sh2_q = 1'b0;
  always @(negedge clk) begin
    div = div + 1;
    phim_pcen_n = div[0];
    phi1_pcen_n = (div[1:0] != 2'd0);
    phi1_ncen_n = (div[1:0] != 2'd2);
    if (o_REG_WE) begin
      if (we_run == 0) we_cnt = we_cnt + 1;
      we_run = we_run + 1;
      if (we_run > we_maxrun) we_maxrun = we_run;
      we_addr = o_REG_ADDR;
      we_data = o_REG_DATA;
    end else we_run = 0;
    if (bus.o_D[7]) busy_clks = busy_clks + 1;
    if (sh1_q && !o_SH1) begin word_r = so_sh[15:3]; lead_r = so_sh[2:0]; end
    if (sh2_q && !o_SH2) begin word_l = so_sh[15:3]; lead_l = so_sh[2:0]; end
    sh1_q = o_SH1;
    sh2_q = o_SH2;
    if (!phi1_pcen_n) so_sh = {o_SO, so_sh[15:1]};
  end

  task automatic cpu_write(input logic a0, input logic [7:0] d);
    @(negedge clk); #1;
    bus.i_A0 = a0; bus.i_D = d; bus.i_CS_n = 1'b0; bus.i_WR_n = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    bus.i_CS_n = 1'b1; bus.i_WR_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic read_status(output logic [7:0] v, output logic oe);
    @(negedge clk); #1;
    bus.i_CS_n = 1'b0; bus.i_RD_n = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    v = bus.o_D; oe = bus.o_D_OE;
    bus.i_CS_n = 1'b1; bus.i_RD_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Waits for a rising edge of SH1 (sel=0) or SH2 (sel=1), or busy falling (sel=2), within a clock budget
  task automatic wait_event(input int sel, input int budget, output bit ok);
    logic prev, cur;
    ok = 1'b0;
    @(negedge clk); #1;
    prev = (sel == 0) ? o_SH1 : (sel == 1) ? o_SH2 : ~bus.o_D[7];
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      cur = (sel == 0) ? o_SH1 : (sel == 1) ? o_SH2 : ~bus.o_D[7];
      if (cur && !prev) begin ok = 1'b1; break; end
      prev = cur;
    end
  endtask

  task automatic test_reset;
    ic = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    tests_run++; if (o_IRQ_n !== 1'b1) begin tests_failed++; $display("FAIL rst_irq_n got %b want 1", o_IRQ_n); end
    tests_run++; if (bus.o_D_OE !== 1'b0) begin tests_failed++; $display("FAIL rst_d_oe got %b want 0", bus.o_D_OE); end
    tests_run++; if ({o_SO, o_SH1, o_SH2} !== 3'b000) begin tests_failed++; $display("FAIL rst_dac got %b want 000", {o_SO, o_SH1, o_SH2}); end
    tests_run++; if ({o_CT1, o_CT2} !== 2'b00) begin tests_failed++; $display("FAIL rst_ct got %b want 00", {o_CT1, o_CT2}); end
    tests_run++; if (bus.o_D !== 8'h00) begin tests_failed++; $display("FAIL rst_status got %h want 00", bus.o_D); end
    tests_run++; if ({o_REG_WE, o_phi1} !== 2'b00) begin tests_failed++; $display("FAIL rst_we_phi1 got %b want 00", {o_REG_WE, o_phi1}); end
    tests_run++; if (o_EMU_L_EX !== 16'h0000) begin tests_failed++; $display("FAIL rst_emu_ex got %h want 0000", o_EMU_L_EX); end
    ic = 1'b0;
  endtask

  task automatic test_ct_busy;
    logic [7:0] v; logic oe; bit ok;
    cpu_write(1'b0, 8'h1B);
    busy_clks = 0;
    cpu_write(1'b1, 8'hC0);
    tests_run++; if ({o_CT1, o_CT2} !== 2'b11) begin tests_failed++; $display("FAIL ct_pins got %b want 11", {o_CT1, o_CT2}); end
    read_status(v, oe);
    tests_run++; if (v !== 8'h80) begin tests_failed++; $display("FAIL busy_status got %h want 80", v); end
    tests_run++; if (oe !== 1'b1) begin tests_failed++; $display("FAIL read_oe got %b want 1", oe); end
    wait_event(2, 300, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL busy_end timeout got 0 want 1"); end
    tests_run++; if (busy_clks < 125 || busy_clks > 128) begin tests_failed++; $display("FAIL busy_len got %0d clk want 125..128", busy_clks); end
    read_status(v, oe);
    tests_run++; if (v !== 8'h00) begin tests_failed++; $display("FAIL idle_status got %h want 00", v); end
  endtask

  task automatic test_reg_we;
    int we0;
    we0 = we_cnt; we_maxrun = 0;
    cpu_write(1'b0, 8'h28);
    cpu_write(1'b1, 8'h42);
    tests_run++; if (we_cnt - we0 !== 1) begin tests_failed++; $display("FAIL we_count got %0d want 1", we_cnt - we0); end
    tests_run++; if (we_maxrun !== 1) begin tests_failed++; $display("FAIL we_width got %0d want 1", we_maxrun); end
    tests_run++; if ({we_addr, we_data} !== 16'h2842) begin tests_failed++; $display("FAIL we_addr_data got %h want 2842", {we_addr, we_data}); end
  endtask

  task automatic test_back_to_back;
    bit ok; int we0;
    we0 = we_cnt;
    repeat (200) @(negedge clk);
    busy_clks = 0;
    cpu_write(1'b1, 8'h43);
    cpu_write(1'b1, 8'h44);
    wait_event(2, 300, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL b2b_busy_end timeout got 0 want 1"); end
    tests_run++; if (busy_clks < 141 || busy_clks > 144) begin tests_failed++; $display("FAIL b2b_busy_len got %0d clk want 141..144", busy_clks); end
    tests_run++; if ({we_cnt - we0, we_addr, we_data} !== {32'd2, 16'h2844}) begin tests_failed++; $display("FAIL b2b_we got n=%0d %h%h want n=2 2844", we_cnt - we0, we_addr, we_data); end
  endtask

  task automatic test_timer_a;
    bit ok; logic [7:0] v; logic oe;
    wait_event(0, 300, ok);
    cpu_write(1'b0, 8'h10); cpu_write(1'b1, 8'hFF);
    cpu_write(1'b0, 8'h11); cpu_write(1'b1, 8'h03);
    cpu_write(1'b0, 8'h14); cpu_write(1'b1, 8'h05);
    ok = 1'b0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk); #1;
      if (!o_IRQ_n) begin ok = 1'b1; break; end
    end
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL tmra_irq timeout got IRQ_n=%b want 0", o_IRQ_n); end
    read_status(v, oe);
    tests_run++; if (v[1:0] !== 2'b01) begin tests_failed++; $display("FAIL tmra_flags got %b want 01", v[1:0]); end
    wait_event(0, 300, ok);
    cpu_write(1'b0, 8'h14); cpu_write(1'b1, 8'h10);
    tests_run++; if (o_IRQ_n !== 1'b1) begin tests_failed++; $display("FAIL tmra_clear got IRQ_n=%b want 1", o_IRQ_n); end
    read_status(v, oe);
    tests_run++; if (v !== 8'h80) begin tests_failed++; $display("FAIL tmra_clear_status got %h want 80", v); end
    cpu_write(1'b1, 8'h01);
    repeat (400) @(negedge clk);
    #1;
    tests_run++; if ({o_IRQ_n, bus.o_D[0]} !== 2'b10) begin tests_failed++; $display("FAIL tmra_masked got %b want 10", {o_IRQ_n, bus.o_D[0]}); end
    cpu_write(1'b1, 8'h00);
  endtask

  task automatic test_dac;
    smp_r = 16'sh0100; smp_l = 16'shFFFF;
    repeat (400) @(negedge clk);
    #1;
    tests_run++; if (o_EMU_R !== 16'h0100 || o_EMU_R_EX !== 16'h0100) begin tests_failed++; $display("FAIL dac_r_256 got raw %h ex %h want 0100 0100", o_EMU_R, o_EMU_R_EX); end
    tests_run++; if ({lead_r, word_r} !== {3'b000, 13'h0700}) begin tests_failed++; $display("FAIL so_r_256 got lead %b word %h want 000 0700", lead_r, word_r); end
    tests_run++; if (o_EMU_L !== 16'hFFFF || o_EMU_L_EX !== 16'hFFFF) begin tests_failed++; $display("FAIL dac_l_m1 got raw %h ex %h want FFFF FFFF", o_EMU_L, o_EMU_L_EX); end
    tests_run++; if ({lead_l, word_l} !== {3'b000, 13'h05FF}) begin tests_failed++; $display("FAIL so_l_m1 got lead %b word %h want 000 05FF", lead_l, word_l); end
    smp_r = 16'sh7FFF; smp_l = -16'sh8000;
    repeat (400) @(negedge clk);
    #1;
    tests_run++; if (o_EMU_R_EX !== 16'h7FC0 || word_r !== 13'h1FFF) begin tests_failed++; $display("FAIL dac_r_max got ex %h word %h want 7FC0 1FFF", o_EMU_R_EX, word_r); end
    tests_run++; if (o_EMU_L_EX !== 16'h8000 || word_l !== 13'h1C00) begin tests_failed++; $display("FAIL dac_l_min got ex %h word %h want 8000 1C00", o_EMU_L_EX, word_l); end
  endtask

  task automatic test_reset_midframe;
    bit ok; int cnt;
    wait_event(1, 300, ok);
    repeat (5) @(negedge clk);
    #1;
    ic = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    ic = 1'b0;
    tests_run++; if ({o_SH1, o_SH2, o_CT1, o_CT2} !== 4'b0000) begin tests_failed++; $display("FAIL mid_rst_outs got %b want 0000", {o_SH1, o_SH2, o_CT1, o_CT2}); end
    tests_run++; if (o_EMU_R !== 16'h0000) begin tests_failed++; $display("FAIL mid_rst_emu got %h want 0000", o_EMU_R); end
    cnt = phi1_pcen_n ? 0 : 1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (o_SH1) begin ok = 1'b1; break; end
      if (!phi1_pcen_n) cnt++;
    end
    tests_run++; if (!ok || cnt !== 8) begin tests_failed++; $display("FAIL mid_rst_slot got %0d phi1 to SH1 (seen=%b) want 8", cnt, ok); end
  endtask

  initial begin
    bus.i_CS_n = 1'b1; bus.i_RD_n = 1'b1; bus.i_WR_n = 1'b1; bus.i_A0 = 1'b0; bus.i_D = 8'h00;
    test_reset();
    test_ct_busy();
    test_reg_we();
    test_back_to_back();
    test_timer_a();
    test_dac();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired got running want finished");
    $fatal(1, "watchdog");
  end

endmodule
